// File: rtl/rast_pkg.sv
// Shared rasterizer types and sizing for the hit merge path.
package rast_pkg;

   localparam int SIGFIG     = 24;
   localparam int RADIX      = 10;
   localparam int AXIS       = 3;
   localparam int COLORS     = 3;
   localparam int FIFO_DEPTH = 8;
   localparam int SKID       = 2;

   localparam int ADDR_W = $clog2(FIFO_DEPTH);
   localparam int PTR_W  = ADDR_W + 1;

   localparam logic LANE0 = 1'b0;
   localparam logic LANE1 = 1'b1;

   typedef logic [AXIS-1:0][SIGFIG-1:0]   pos_t;
   typedef logic [COLORS-1:0][SIGFIG-1:0] color_t;

   typedef struct packed {
      pos_t   pos;
      color_t color;
   } hit_t;

endpackage

// File: rtl/hit_lane_fifo.sv
// Per-lane hit FIFO with a registered upstream halt that leaves SKID free slots.
module hit_lane_fifo
   import rast_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic push,
   input  hit_t din,
   input  logic pop,
   output hit_t head,
   output logic empty,
   output logic halt,
   output logic overflow
);

   localparam logic [PTR_W-1:0] DEPTH_LEVEL = PTR_W'(FIFO_DEPTH);
   localparam logic [PTR_W-1:0] HALT_LEVEL  = PTR_W'(FIFO_DEPTH - SKID);

   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] count;
   logic [PTR_W-1:0] count_next;
   logic             full;
   logic             pop_ok;
   logic             push_ok;
   hit_t             mem [FIFO_DEPTH];

   // A pop in the same cycle frees the slot, so a push into a full FIFO is still taken.
   always_comb begin
      count      = wr_ptr - rd_ptr;
      full       = (count == DEPTH_LEVEL);
      empty      = (count == '0);
      pop_ok     = pop && !empty;
      push_ok    = push && (!full || pop_ok);
      overflow   = push && !push_ok;
      count_next = count + PTR_W'(push_ok) - PTR_W'(pop_ok);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         halt   <= 1'b0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + 1'b1;
         if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
         halt <= (count_next >= HALT_LEVEL);
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr[ADDR_W-1:0]] <= din;
   end

   assign head = mem[rd_ptr[ADDR_W-1:0]];

endmodule

// File: rtl/hit_stream_merger.sv
// Merges the two sample-test hit lanes into one round-robin valid/ready stream.
module hit_stream_merger
   import rast_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  pos_t        hit_R18S,
   input  color_t      color_R18U,
   input  logic        hit_valid_R18H,
   input  pos_t        hit_R19S,
   input  color_t      color_R19U,
   input  logic        hit_valid_R19H,
   output logic        halt0_RnnL,
   output logic        halt1_RnnL,
   output pos_t        hit_out_S,
   output color_t      color_out_U,
   output logic        lane_out_H,
   output logic        valid_out_H,
   input  logic        ready_in_H,
   output logic [31:0] merged_count,
   output logic        overflow_H
);

   hit_t in0, in1, head0, head1, winner;
   logic empty0, empty1;
   logic ovf0, ovf1;
   logic pop0, pop1;
   logic load, contended, grant, rr_ptr;

   assign in0 = '{pos: hit_R18S, color: color_R18U};
   assign in1 = '{pos: hit_R19S, color: color_R19U};

   hit_lane_fifo u_fifo0 (
      .clk      (clk),
      .rst      (rst),
      .push     (hit_valid_R18H),
      .din      (in0),
      .pop      (pop0),
      .head     (head0),
      .empty    (empty0),
      .halt     (halt0_RnnL),
      .overflow (ovf0)
   );

   hit_lane_fifo u_fifo1 (
      .clk      (clk),
      .rst      (rst),
      .push     (hit_valid_R19H),
      .din      (in1),
      .pop      (pop1),
      .head     (head1),
      .empty    (empty1),
      .halt     (halt1_RnnL),
      .overflow (ovf1)
   );

   // The round-robin pointer only decides contended grants.
   always_comb begin
      contended = !empty0 && !empty1;
      load      = (!valid_out_H || ready_in_H) && (!empty0 || !empty1);
      grant     = contended ? rr_ptr : (empty0 ? LANE1 : LANE0);
      pop0      = load && (grant == LANE0);
      pop1      = load && (grant == LANE1);
      winner    = (grant == LANE1) ? head1 : head0;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         hit_out_S    <= '0;
         color_out_U  <= '0;
         lane_out_H   <= LANE0;
         valid_out_H  <= 1'b0;
         rr_ptr       <= LANE0;
         merged_count <= '0;
         overflow_H   <= 1'b0;
      end else begin
         if (load) begin
            hit_out_S   <= winner.pos;
            color_out_U <= winner.color;
            lane_out_H  <= grant;
            valid_out_H <= 1'b1;
         end else if (ready_in_H) begin
            valid_out_H <= 1'b0;
         end
         if (load && contended) rr_ptr <= ~grant;
         if (valid_out_H && ready_in_H) merged_count <= merged_count + 32'd1;
         if (ovf0 || ovf1) overflow_H <= 1'b1;
      end
   end

endmodule

// File: tb/tb_hit_stream_merger.sv
// Directed, self-checking bench for hit_stream_merger: vector table plus corner-case sequences.
module tb_hit_stream_merger;
   import rast_pkg::*;

   logic        clk;
   logic        rst;
   pos_t        hit_r18, hit_r19, hit_out;
   color_t      color_r18, color_r19, color_out;
   logic        valid_r18, valid_r19;
   logic        halt0, halt1, lane_out, valid_out, ready_in, overflow;
   logic [31:0] merged_count;

   int checks;
   int failures;

   typedef struct {
      logic        push0;
      logic [23:0] tag0;
      logic        push1;
      logic [23:0] tag1;
      logic        ready;
      logic        exp_valid;
      logic        exp_lane;
      logic [23:0] exp_tag;
      logic [31:0] exp_count;
   } vec_t;

   vec_t vecs [9];

   hit_stream_merger dut (
      .clk            (clk),
      .rst            (rst),
      .hit_R18S       (hit_r18),
      .color_R18U     (color_r18),
      .hit_valid_R18H (valid_r18),
      .hit_R19S       (hit_r19),
      .color_R19U     (color_r19),
      .hit_valid_R19H (valid_r19),
      .halt0_RnnL     (halt0),
      .halt1_RnnL     (halt1),
      .hit_out_S      (hit_out),
      .color_out_U    (color_out),
      .lane_out_H     (lane_out),
      .valid_out_H    (valid_out),
      .ready_in_H     (ready_in),
      .merged_count   (merged_count),
      .overflow_H     (overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic hit_t mk_hit(input logic [23:0] tag);
      hit_t h;
      for (int a = 0; a < AXIS; a++)   h.pos[a]   = tag + 24'(a);
      for (int c = 0; c < COLORS; c++) h.color[c] = tag + 24'(c + 3);
      return h;
   endfunction

   task automatic apply_stimulus(input logic p0, input logic [23:0] t0,
                                 input logic p1, input logic [23:0] t1, input logic rdy);
      hit_t h0, h1;
      h0 = mk_hit(t0);
      h1 = mk_hit(t1);
      valid_r18 = p0;
      hit_r18   = h0.pos;
      color_r18 = h0.color;
      valid_r19 = p1;
      hit_r19   = h1.pos;
      color_r19 = h1.color;
      ready_in  = rdy;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_output(input string name, input logic [71:0] act, input logic [71:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic check_hit(input string name, input logic lane, input logic [23:0] tag);
      hit_t h;
      h = mk_hit(tag);
      check_output({name, ".valid"}, 72'(valid_out), 72'd1);
      check_output({name, ".lane"},  72'(lane_out), 72'(lane));
      check_output({name, ".pos"},   hit_out, h.pos);
      check_output({name, ".color"}, color_out, h.color);
   endtask

   task automatic check_all_zero(input string name);
      check_output({name, ".valid"},    72'(valid_out), 72'd0);
      check_output({name, ".lane"},     72'(lane_out), 72'd0);
      check_output({name, ".halt0"},    72'(halt0), 72'd0);
      check_output({name, ".halt1"},    72'(halt1), 72'd0);
      check_output({name, ".count"},    72'(merged_count), 72'd0);
      check_output({name, ".overflow"}, 72'(overflow), 72'd0);
      check_output({name, ".pos"},      hit_out, 72'd0);
      check_output({name, ".color"},    color_out, 72'd0);
   endtask

   initial begin
      hit_t h;
      int   n0, n1, e0, e1;
      logic exp_lane, seen0, seen1;

      checks   = 0;
      failures = 0;

      vecs[0] = '{1'b1, 24'h10, 1'b0, 24'h0,  1'b1, 1'b0, 1'b0, 24'h0,  32'd1};
      vecs[1] = '{1'b1, 24'h11, 1'b1, 24'h20, 1'b1, 1'b1, 1'b0, 24'h10, 32'd1};
      vecs[2] = '{1'b0, 24'h0,  1'b0, 24'h0,  1'b1, 1'b1, 1'b0, 24'h11, 32'd2};
      vecs[3] = '{1'b0, 24'h0,  1'b0, 24'h0,  1'b1, 1'b1, 1'b1, 24'h20, 32'd3};
      vecs[4] = '{1'b1, 24'h12, 1'b1, 24'h21, 1'b1, 1'b0, 1'b0, 24'h0,  32'd4};
      vecs[5] = '{1'b0, 24'h0,  1'b0, 24'h0,  1'b1, 1'b1, 1'b1, 24'h21, 32'd4};
      vecs[6] = '{1'b0, 24'h0,  1'b0, 24'h0,  1'b1, 1'b1, 1'b0, 24'h12, 32'd5};
      vecs[7] = '{1'b0, 24'h0,  1'b0, 24'h0,  1'b0, 1'b1, 1'b0, 24'h12, 32'd5};
      vecs[8] = '{1'b0, 24'h0,  1'b0, 24'h0,  1'b1, 1'b0, 1'b0, 24'h0,  32'd6};

      rst = 1'b0;
      apply_stimulus(1'b0, 24'h0, 1'b0, 24'h0, 1'b0);
      tick();
      tick();
      check_all_zero("reset_init");
      rst = 1'b1;

      // Single lane-0 hit with explicit position and color.
      h.pos[0] = 24'd5; h.pos[1] = 24'd7; h.pos[2] = 24'd9;
      h.color[0] = 24'd1; h.color[1] = 24'd2; h.color[2] = 24'd3;
      apply_stimulus(1'b0, 24'h0, 1'b0, 24'h0, 1'b1);
      valid_r18 = 1'b1;
      hit_r18   = h.pos;
      color_r18 = h.color;
      tick();
      check_output("single.latency", 72'(valid_out), 72'd0);
      apply_stimulus(1'b0, 24'h0, 1'b0, 24'h0, 1'b1);
      tick();
      check_output("single.valid", 72'(valid_out), 72'd1);
      check_output("single.lane",  72'(lane_out), 72'd0);
      check_output("single.pos",   hit_out, h.pos);
      check_output("single.color", color_out, h.color);
      tick();
      check_output("single.count", 72'(merged_count), 72'd1);
      check_output("single.drain", 72'(valid_out), 72'd0);

      for (int i = 0; i < 9; i++) begin
         apply_stimulus(vecs[i].push0, vecs[i].tag0, vecs[i].push1, vecs[i].tag1, vecs[i].ready);
         tick();
         check_output($sformatf("vec%0d.valid", i), 72'(valid_out), 72'(vecs[i].exp_valid));
         check_output($sformatf("vec%0d.count", i), 72'(merged_count), 72'(vecs[i].exp_count));
         check_output($sformatf("vec%0d.halts", i), 72'({halt0, halt1}), 72'd0);
         if (vecs[i].exp_valid)
            check_hit($sformatf("vec%0d", i), vecs[i].exp_lane, vecs[i].exp_tag);
      end

      // Stalled output with lane 1 filling up to the halt threshold.
      apply_stimulus(1'b1, 24'h3F, 1'b0, 24'h0, 1'b0);
      tick();
      apply_stimulus(1'b0, 24'h0, 1'b0, 24'h0, 1'b0);
      tick();
      check_hit("stall.preload", 1'b0, 24'h3F);
      for (int i = 0; i < 20; i++) begin
         apply_stimulus(1'b0, 24'h0, i < 6, 24'(24'h40 + i), 1'b0);
         tick();
         check_hit($sformatf("stall.hold%0d", i), 1'b0, 24'h3F);
         check_output($sformatf("stall.halt1_%0d", i), 72'(halt1), 72'(i >= 5));
         check_output($sformatf("stall.count%0d", i), 72'(merged_count), 72'd6);
      end
      for (int i = 0; i < 7; i++) begin
         apply_stimulus(1'b0, 24'h0, 1'b0, 24'h0, 1'b1);
         tick();
         check_output($sformatf("release.count%0d", i), 72'(merged_count), 72'(7 + i));
         if (i < 6) begin
            check_hit($sformatf("release%0d", i), 1'b1, 24'(24'h40 + i));
            check_output($sformatf("release.halt1_%0d", i), 72'(halt1), 72'd0);
         end else begin
            check_output("release.empty", 72'(valid_out), 72'd0);
         end
      end

      // Full lane-0 FIFO taking a push in the same cycle it pops.
      apply_stimulus(1'b1, 24'h50, 1'b0, 24'h0, 1'b0);
      tick();
      apply_stimulus(1'b0, 24'h0, 1'b0, 24'h0, 1'b0);
      tick();
      for (int i = 0; i < 8; i++) begin
         apply_stimulus(1'b1, 24'(24'h60 + i), 1'b0, 24'h0, 1'b0);
         tick();
         check_output($sformatf("fill.halt0_%0d", i), 72'(halt0), 72'(i >= 5));
      end
      apply_stimulus(1'b1, 24'h6A, 1'b0, 24'h0, 1'b1);
      tick();
      check_hit("fullpush.out", 1'b0, 24'h60);
      check_output("fullpush.overflow", 72'(overflow), 72'd0);
      check_output("fullpush.halt0", 72'(halt0), 72'd1);
      check_output("fullpush.count", 72'(merged_count), 72'd14);
      for (int j = 1; j <= 8; j++) begin
         apply_stimulus(1'b0, 24'h0, 1'b0, 24'h0, 1'b1);
         tick();
         check_hit($sformatf("fulldrain%0d", j), 1'b0, (j <= 7) ? 24'(24'h60 + j) : 24'h6A);
         check_output($sformatf("fulldrain.halt0_%0d", j), 72'(halt0), 72'(j <= 2));
         check_output($sformatf("fulldrain.count%0d", j), 72'(merged_count), 72'(14 + j));
      end
      tick();
      check_output("fulldrain.empty", 72'(valid_out), 72'd0);
      check_output("fulldrain.count", 72'(merged_count), 72'd23);
      check_output("fulldrain.overflow", 72'(overflow), 72'd0);

      // Upstream ignoring halt: the 9th and 10th pushes are dropped.
      apply_stimulus(1'b1, 24'h70, 1'b0, 24'h0, 1'b0);
      tick();
      apply_stimulus(1'b0, 24'h0, 1'b0, 24'h0, 1'b0);
      tick();
      for (int i = 0; i < 10; i++) begin
         apply_stimulus(1'b1, 24'(24'h80 + i), 1'b0, 24'h0, 1'b0);
         tick();
         check_output($sformatf("ovf.flag%0d", i), 72'(overflow), 72'(i >= 8));
         check_output($sformatf("ovf.halt0_%0d", i), 72'(halt0), 72'(i >= 5));
      end
      apply_stimulus(1'b0, 24'h0, 1'b0, 24'h0, 1'b0);
      tick();
      tick();
      check_output("ovf.sticky", 72'(overflow), 72'd1);
      for (int j = 0; j < 9; j++) begin
         apply_stimulus(1'b0, 24'h0, 1'b0, 24'h0, 1'b1);
         tick();
         check_output($sformatf("ovfdrain.count%0d", j), 72'(merged_count), 72'(24 + j));
         if (j < 8) check_hit($sformatf("ovfdrain%0d", j), 1'b0, 24'(24'h80 + j));
         else       check_output("ovfdrain.empty", 72'(valid_out), 72'd0);
      end
      check_output("ovfdrain.sticky", 72'(overflow), 72'd1);

      // Asynchronous reset in the middle of a two-lane burst.
      for (int i = 0; i < 3; i++) begin
         apply_stimulus(1'b1, 24'(24'h90 + i), 1'b1, 24'(24'hA0 + i), 1'b1);
         tick();
      end
      #2;
      rst = 1'b0;
      #1;
      check_all_zero("async_reset");
      for (int i = 0; i < 3; i++) begin
         tick();
         check_all_zero($sformatf("in_reset%0d", i));
      end
      rst = 1'b1;
      apply_stimulus(1'b0, 24'h0, 1'b1, 24'h99, 1'b1);
      tick();
      check_output("postreset.latency", 72'(valid_out), 72'd0);
      apply_stimulus(1'b0, 24'h0, 1'b0, 24'h0, 1'b1);
      tick();
      check_hit("postreset.first", 1'b1, 24'h99);
      tick();
      check_output("postreset.count", 72'(merged_count), 72'd1);
      check_output("postreset.empty", 72'(valid_out), 72'd0);

      // Both lanes pushing while honouring halt; grants must alternate 0,1,0,1.
      n0 = 0; n1 = 0; e0 = 0; e1 = 0;
      exp_lane = 1'b0;
      seen0 = 1'b0; seen1 = 1'b0;
      for (int c = 0; c < 40; c++) begin
         apply_stimulus(!halt0, 24'(24'hA00 + n0), !halt1, 24'(24'hB00 + n1), 1'b1);
         if (valid_r18) n0++;
         if (valid_r19) n1++;
         tick();
         seen0 |= halt0;
         seen1 |= halt1;
         check_output($sformatf("rr.valid%0d", c), 72'(valid_out), 72'(c >= 1));
         if (valid_out) begin
            if (exp_lane == 1'b0) begin
               check_hit($sformatf("rr%0d", c), 1'b0, 24'(24'hA00 + e0));
               e0++;
            end else begin
               check_hit($sformatf("rr%0d", c), 1'b1, 24'(24'hB00 + e1));
               e1++;
            end
            exp_lane = ~exp_lane;
         end
      end
      apply_stimulus(1'b0, 24'h0, 1'b0, 24'h0, 1'b1);
      check_output("rr.halt0_seen", 72'(seen0), 72'd1);
      check_output("rr.halt1_seen", 72'(seen1), 72'd1);
      check_output("rr.overflow", 72'(overflow), 72'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
